// File: rtl/rv_pkg.sv
// rv_pkg: register-file geometry shared by the decode-stage blocks.
//   REG_W      - architectural register address width
//   NUM_REGS   - number of architectural registers (x0 included)
//   reg_addr_t - register address type
package rv_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// sb_counter: pending-write counter for one architectural register.
// Counts up on an issued write and down on writebacks/kills (up to two
// retires per cycle). The result is clamped to 0..MAX_CNT.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   inc           - one new pending write this cycle
//   dec[1:0]      - number of retires this cycle (0..2)
//   cnt           - current count
//   is_zero       - count is zero
module sb_counter #(
    parameter int unsigned MAX_CNT = 3,
    parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero
);

    localparam logic [CNT_W:0] MAX_V = (CNT_W + 1)'(MAX_CNT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   w_dec;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W:0]   w_next;

    assign w_sum  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, inc};
    assign w_diff = w_sum - w_dec;

    always_comb begin
        w_dec      = '0;
        w_dec[1:0] = dec;
    end

    always_comb begin
        w_next = w_diff;
        if (w_dec > w_sum) begin
            w_next = '0;
        end else if (w_diff > MAX_V) begin
            w_next = MAX_V;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next[CNT_W-1:0];
        end
    end

    // Retiring more writes than are pending is a protocol error upstream.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) w_dec <= w_sum);

    assign cnt     = r_cnt;
    assign is_zero = (r_cnt == '0);

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: register-hazard scoreboard and issue controller for ID.
// Tracks in-flight register writes per register (x1..x31) and stalls a
// decoded instruction on a RAW hazard against a pending write or when its
// destination counter is already full.
// Optional feature macro: SCOREBOARD_BYPASS_EN - a source whose last pending
// write is being written back this cycle is not treated as a hazard (relies
// on regfile write-through or a forward path).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   id_valid            - ID holds a decoded instruction
//   ra1, ra2, use1, use2- source addresses and their read enables
//   we3_out, wa3_out    - destination write enable/address of the ID instr
//   ex_ready            - downstream accepts an instruction this cycle
//   we3_in, wa3_in      - regfile writeback enable/address
//   kill_valid, kill_wa - squashed writing instruction and its destination
//   stall               - hold IF/ID
//   issue               - ID instruction advances
//   busy                - any write is pending
module id_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] ra1,
    input  logic [REG_W-1:0] ra2,
    input  logic             use1,
    input  logic             use2,
    input  logic             we3_out,
    input  logic [REG_W-1:0] wa3_out,
    input  logic             ex_ready,
    input  logic             we3_in,
    input  logic [REG_W-1:0] wa3_in,
    input  logic             kill_valid,
    input  logic [REG_W-1:0] kill_wa,
    output logic             stall,
    output logic             issue,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef logic [CNT_W-1:0] pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = pend_cnt_t'(MAX_INFLIGHT);
    localparam pend_cnt_t PEND_ONE = pend_cnt_t'(1);

    pend_cnt_t w_pend [NUM_REGS];
    logic      w_zero [1:NUM_REGS-1];
    logic      w_issue;
    logic      w_raw;
    logic      w_cap;
    logic      w_res1;
    logic      w_res2;
    pend_cnt_t w_p1;
    pend_cnt_t w_p2;
    pend_cnt_t w_pw;

    // x0 is never tracked; its entry reads as permanently empty.
    assign w_pend[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        logic       w_inc;
        logic [1:0] w_dec;

        assign w_inc = w_issue && we3_out && (wa3_out == reg_addr_t'(g));
        assign w_dec = {1'b0, we3_in && (wa3_in == reg_addr_t'(g))}
                     + {1'b0, kill_valid && (kill_wa == reg_addr_t'(g))};

        sb_counter #(
            .MAX_CNT (MAX_INFLIGHT),
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (w_inc),
            .dec     (w_dec),
            .cnt     (w_pend[g]),
            .is_zero (w_zero[g])
        );
    end

    assign w_p1 = w_pend[ra1];
    assign w_p2 = w_pend[ra2];
    assign w_pw = w_pend[wa3_out];

`ifdef SCOREBOARD_BYPASS_EN
    // Only the last outstanding write may be bypassed; an older one still
    // leaves a younger write pending.
    assign w_res1 = we3_in && (wa3_in == ra1) && (w_p1 == PEND_ONE);
    assign w_res2 = we3_in && (wa3_in == ra2) && (w_p2 == PEND_ONE);
`else
    assign w_res1 = 1'b0;
    assign w_res2 = 1'b0;
`endif

    assign w_raw = (use1 && (w_p1 != '0) && !w_res1)
                || (use2 && (w_p2 != '0) && !w_res2);

    assign w_cap = we3_out && (wa3_out != '0) && (w_pw == PEND_MAX);

    assign w_issue = id_valid && ex_ready && !w_raw && !w_cap && !reset;

    assign issue = w_issue;
    assign stall = id_valid && !w_issue;

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            busy = busy | !w_zero[i];
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXF = 3;

    logic       clk = 1'b0;
    logic       reset, id_valid, use1, use2, we3_out, ex_ready, we3_in, kill_valid;
    logic [4:0] ra1, ra2, wa3_out, wa3_in, kill_wa;
    logic       stall, issue, busy;

    int total = 0;
    int bad   = 0;

    int pend_m [32];

    always #5 clk = ~clk;

    id_scoreboard #(.MAX_INFLIGHT(MAXF)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .ra1        (ra1),
        .ra2        (ra2),
        .use1       (use1),
        .use2       (use2),
        .we3_out    (we3_out),
        .wa3_out    (wa3_out),
        .ex_ready   (ex_ready),
        .we3_in     (we3_in),
        .wa3_in     (wa3_in),
        .kill_valid (kill_valid),
        .kill_wa    (kill_wa),
        .stall      (stall),
        .issue      (issue),
        .busy       (busy)
    );

    typedef struct {
        logic       rst, idv;
        logic [4:0] ra1;
        logic       u1;
        logic [4:0] ra2;
        logic       u2, we;
        logic [4:0] wa;
        logic       ex, wbe;
        logic [4:0] wba;
        logic       kv;
        logic [4:0] kwa;
        logic       e_iss, e_stl, e_bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic idv, int a1, logic u1, int a2, logic u2,
                                logic we, int wa, logic ex, logic wbe, int wba,
                                logic kv, int kwa, logic ei, logic es, logic eb);
        vec_t v;
        v.rst = rst; v.idv = idv; v.ra1 = 5'(a1); v.u1 = u1; v.ra2 = 5'(a2); v.u2 = u2;
        v.we = we; v.wa = 5'(wa); v.ex = ex; v.wbe = wbe; v.wba = 5'(wba);
        v.kv = kv; v.kwa = 5'(kwa); v.e_iss = ei; v.e_stl = es; v.e_bsy = eb;
        return v;
    endfunction

    task automatic drive(vec_t v);
        reset = v.rst; id_valid = v.idv; ra1 = v.ra1; use1 = v.u1; ra2 = v.ra2; use2 = v.u2;
        we3_out = v.we; wa3_out = v.wa; ex_ready = v.ex; we3_in = v.wbe; wa3_in = v.wba;
        kill_valid = v.kv; kill_wa = v.kwa;
    endtask

    task automatic check(string name, int idx, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Reference: hazard/issue decision straight from the scoreboard rules.
    function automatic logic model_issue();
        logic raw, cap, r1, r2;
        r1  = BYP && we3_in && (wa3_in == ra1) && (pend_m[ra1] == 1);
        r2  = BYP && we3_in && (wa3_in == ra2) && (pend_m[ra2] == 1);
        raw = (use1 && pend_m[ra1] > 0 && !r1) || (use2 && pend_m[ra2] > 0 && !r2);
        cap = we3_out && wa3_out != 0 && pend_m[wa3_out] == MAXF;
        return id_valid && ex_ready && !raw && !cap && !reset;
    endfunction

    function automatic logic model_busy();
        for (int r = 1; r < 32; r++) if (pend_m[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update(logic iss);
        if (reset) begin
            foreach (pend_m[r]) pend_m[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                int v;
                v = pend_m[r];
                if (iss && we3_out && wa3_out == r) v++;
                if (we3_in && wa3_in == r) v--;
                if (kill_valid && kill_wa == r) v--;
                pend_m[r] = (v < 0) ? 0 : v;
            end
        end
    endtask

    // Pending register (not x0) with more than `need` outstanding writes.
    function automatic int find_pending(int start, int skip, int need_skip);
        for (int i = 0; i < 32; i++) begin
            int r;
            r = (start + i) % 32;
            if (r != 0 && pend_m[r] > ((r == skip) ? need_skip : 0)) return r;
        end
        return -1;
    endfunction

    initial begin
        logic e_iss;
        int   r, k;

        drive(mk(1,0, 0,0,0,0, 0,0, 1, 0,0, 0,0, 0,0,0));
        @(posedge clk); #1;

        // rst idv ra1 u1 ra2 u2 we wa ex wbe wba kv kwa | iss stl bsy
        tbl.push_back(mk(1,1, 0,0, 0,0, 0,0, 1, 0,0, 0,0,  0,1,0));
        tbl.push_back(mk(0,1, 5,1, 0,1, 0,0, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 0,0, 0,0,  0,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,7, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 7,1, 0,0, 0,0, 1, 0,0, 0,0,  0,1,1));
        tbl.push_back(mk(0,1, 7,1, 0,0, 0,0, 1, 1,7, 0,0,  BYP,!BYP,1));
        tbl.push_back(mk(0,1, 7,1, 0,0, 0,0, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,3, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,3, 1, 0,0, 0,0,  1,0,1));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,3, 1, 0,0, 0,0,  1,0,1));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,3, 1, 0,0, 0,0,  0,1,1));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,3, 1, 1,3, 0,0,  0,1,1));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,3, 1, 0,0, 0,0,  1,0,1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 1,3, 0,0,  0,0,1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 1,3, 0,0,  0,0,1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 1,3, 0,0,  0,0,1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 0,0, 0,0,  0,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,9, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,9, 1, 1,9, 0,0,  1,0,1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 0,0, 0,0,  0,0,1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 1,9, 0,0,  0,0,1));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 0,0, 0,0,  0,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,0, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,1, 0,1, 0,0, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,12,1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,0,12,1, 0,0, 1, 0,0, 0,0,  0,1,1));
        tbl.push_back(mk(0,1, 0,0,12,1, 0,0, 1, 0,0, 1,12, 0,1,1));
        tbl.push_back(mk(0,1, 0,0,12,1, 0,0, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 0, 0,0, 0,0,  0,1,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,4, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 1,5, 1, 0,0, 0,0,  1,0,1));
        tbl.push_back(mk(0,1, 4,1, 0,0, 0,0, 1, 0,0, 0,0,  0,1,1));
        tbl.push_back(mk(1,1, 4,1, 0,0, 0,0, 1, 0,0, 0,0,  0,1,1));
        tbl.push_back(mk(1,1, 4,1, 0,0, 0,0, 1, 0,0, 0,0,  0,1,0));
        tbl.push_back(mk(0,1, 4,1, 0,0, 0,0, 1, 0,0, 0,0,  1,0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 1,0, 1,0,  0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check("vec_issue", i, issue, tbl[i].e_iss);
            check("vec_stall", i, stall, tbl[i].e_stl);
            check("vec_busy",  i, busy,  tbl[i].e_bsy);
            @(posedge clk); #1;
        end

        // Randomized phase against the reference model, from a clean reset.
        drive(mk(1,0, 0,0,0,0, 0,0, 1, 0,0, 0,0, 0,0,0));
        @(posedge clk); #1;
        foreach (pend_m[i]) pend_m[i] = 0;

        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            ra1        = 5'($urandom_range(0, 7));
            ra2        = 5'($urandom_range(0, 7));
            use1       = 1'($urandom);
            use2       = 1'($urandom);
            we3_out    = 1'($urandom);
            wa3_out    = 5'($urandom_range(0, 7));
            ex_ready   = ($urandom_range(0, 4) != 0);
            we3_in     = 1'b0;
            wa3_in     = 5'($urandom_range(0, 31));
            kill_valid = 1'b0;
            kill_wa    = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                r = find_pending(int'($urandom_range(0, 31)), -1, 0);
                if (r > 0) begin
                    we3_in = 1'b1; wa3_in = 5'(r);
                end else if ($urandom_range(0, 3) == 0) begin
                    we3_in = 1'b1; wa3_in = 5'd0;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                k = find_pending(int'($urandom_range(0, 31)), we3_in ? int'(wa3_in) : -1, 1);
                if (k > 0) begin
                    kill_valid = 1'b1; kill_wa = 5'(k);
                end else if ($urandom_range(0, 3) == 0) begin
                    kill_valid = 1'b1; kill_wa = 5'd0;
                end
            end
            @(negedge clk);
            e_iss = model_issue();
            check("rnd_issue", c, issue, e_iss);
            check("rnd_stall", c, stall, id_valid && !e_iss);
            check("rnd_busy",  c, busy,  model_busy());
            @(posedge clk);
            model_update(e_iss);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
